cnn_frame_loader: RTL and testbench
===================================

Name: cnn_frame_loader

Overview:
- Host-side sequencer for the CNN accelerator.
- Accepts one input image as a 32-bit word stream with a valid/ready handshake.
- Writes the image into the IF1 BRAM through the standard BRAM port set: ADDR, WE, EN, DIN, DOUT.
- Pulses the accelerator's start for one cycle, waits for a fresh done, then returns the 8-bit inference result on a valid/ready output channel.
- Includes a watchdog so a hung accelerator cannot stall the host.

Parameters:
- IMG_WORDS, 256, words per frame (32x32 8-bit pixels packed 4 per word).
- BASE_ADDR, 32'h0, byte address of word 0 in the BRAM.
- TIMEOUT_CYC, 1000000, cycles allowed in RUN before a timeout is declared.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  loader accepts an input word.
- s_data  in  32  input image word.
- mode_in  in  1  network select (1 = number, 0 = letter); latched on the first word of a frame.
- cnn_start  out  1  single-cycle start pulse to the accelerator.
- cnn_mode  out  1  latched mode, held stable from START through REPORT.
- cnn_done  in  1  accelerator done (level).
- cnn_result  in  8  accelerator class result.
- BRAM_IF1_ADDR  out  32  byte address.
- BRAM_IF1_WE  out  4  byte write enables.
- BRAM_IF1_EN  out  1  BRAM enable.
- BRAM_IF1_DIN  out  32  write data.
- BRAM_IF1_DOUT  in  32  read data, 1-cycle latency.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_data  out  8  result or error code.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky until the next frame's first handshake.
- load_err  out  1  readback mismatch (see Optional Feature).

Behaviour:
- Clocking and reset:
  - Single clock.
  - rst is synchronous and active-high; it is sampled at the clk edge and dominates all other inputs.
  - Reset values: all outputs 0; the state machine goes to IDLE; word index, watchdog and latched mode are cleared.
- State machine: IDLE -> LOAD -> FLUSH -> [VERIFY] -> START -> RUN -> REPORT -> IDLE.
- IDLE:
  - s_ready=1.
  - The first handshake (s_valid & s_ready) latches mode_in, clears timeout/load_err, writes word 0 and enters LOAD.
- LOAD:
  - s_ready=1.
  - Each handshake registers a write presented the following cycle:
    - EN=1, WE=4'hF
    - ADDR=BASE_ADDR+4*idx
    - DIN=s_data
  - Cycles without a handshake present EN=0, WE=0.
  - idx counts 0..IMG_WORDS-1. The handshake with idx==IMG_WORDS-1 moves to FLUSH.
  - s_ready drops the cycle after the last handshake.
- FLUSH: one cycle, so the final write is committed before start.
- START:
  - cnn_start=1 for exactly one cycle, 2 cycles after the last handshake (3 with VERIFY).
  - cnn_mode holds the latched value.
- RUN:
  - The watchdog increments every cycle.
  - Done is accepted only on a rising edge: cnn_done=1 with the previous-cycle sample 0; done already high at entry is ignored.
  - On accept: res_data<=cnn_result, go to REPORT.
  - If the watchdog reaches TIMEOUT_CYC-1 without an accept: res_data<=8'hFE, timeout<=1, go to REPORT.
- REPORT:
  - res_valid=1; res_data is stable until res_ready=1.
  - The handshake cycle returns to IDLE.
  - res_valid drops the next cycle.
- Outside IDLE/LOAD: s_ready=0 and s_valid is ignored. BRAM EN/WE=0 except for LOAD writes and VERIFY reads.
- Reset mid-frame: the next cycle shows EN=0, WE=0, s_ready=0, cnn_start=0. The partial frame is discarded and the following frame restarts at BASE_ADDR.

Optional Feature:
- Macro: LOADER_READBACK_EN.
- Defined:
  - LOAD accumulates a 32-bit wrap-around sum of accepted words.
  - FLUSH is followed by VERIFY, which issues IMG_WORDS reads (EN=1, WE=0, consecutive addresses).
  - DOUT is summed one cycle after each read cycle.
  - After the last read data: equal sum -> START. Mismatch -> load_err=1, res_data=8'hFD, go to REPORT without any cnn_start.
- Undefined: no VERIFY state, load_err tied to 0.

Test Plan:
- Stream words 0..255 with mode_in=1 and no stalls; model done at 50 cycles with result 7 -> 256 writes at addresses 0,4,...,1020 with WE=F, DIN=index; one cnn_start exactly 2 cycles after the last handshake; cnn_mode=1; res_valid with res_data=8'd7.
- Random s_valid gaps and res_ready held low 10 cycles -> no skipped or duplicated addresses; res_data=7 stable throughout; s_ready=0 during RUN/REPORT.
- TIMEOUT_CYC=100 with done never rising -> at RUN cycle 100, res_data=8'hFE, timeout=1; no second cnn_start.
- cnn_done left high from the previous run at START -> no accept until done falls and rises; result captured at that rising edge.
- rst asserted after word 100 -> EN=0, s_ready=0 the next cycle; a new frame then writes word 0 at BASE_ADDR and completes normally.
- With LOADER_READBACK_EN and a BRAM model corrupting word 17 -> load_err=1, res_data=8'hFD, no cnn_start. Without the macro, the same stimulus -> load_err=0 and normal start.

Source files
------------

// File: rtl/cnn_frame_loader_if.sv
// Host-facing channels of cnn_frame_loader: the image word stream and the result channel.
interface cnn_frame_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        mode_in;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;

  modport master (output s_valid, s_data, mode_in, res_ready,
                  input  s_ready, res_valid, res_data);
  modport slave  (input  s_valid, s_data, mode_in, res_ready,
                  output s_ready, res_valid, res_data);
endinterface

// File: rtl/cnn_frame_loader.sv
// Streams one image into the IF1 BRAM, pulses the CNN start, and returns its result.
// Define LOADER_READBACK_EN to re-read the frame and compare word sums before start.
module cnn_frame_loader #(
  parameter int unsigned IMG_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  cnn_frame_loader_if.slave io,
  output logic              cnn_start,
  output logic              cnn_mode,
  input  logic              cnn_done,
  input  logic [7:0]        cnn_result,
  output logic [31:0]       BRAM_IF1_ADDR,
  output logic [3:0]        BRAM_IF1_WE,
  output logic              BRAM_IF1_EN,
  output logic [31:0]       BRAM_IF1_DIN,
  input  logic [31:0]       BRAM_IF1_DOUT,
  output logic              busy,
  output logic              timeout,
  output logic              load_err
);
  localparam int IW = $clog2(IMG_WORDS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, VERIFY, START, RUN, REPORT} state_t;
  state_t state, state_n;

  logic [IW-1:0] idx;
  logic [31:0]   wd;
  logic          done_q;
  logic          hs_in, accept, res_hs;

  assign hs_in  = io.s_valid && io.s_ready;
  assign accept = cnn_done && !done_q;
  assign res_hs = io.res_valid && io.res_ready;
  assign busy   = (state != IDLE);

`ifdef LOADER_READBACK_EN
  logic [31:0]   wr_sum, rb_sum;
  logic [IW-1:0] rd_idx, rd_cnt;
  logic          rd_vld, rb_last, rb_ok;
  assign rb_last = rd_vld && (rd_cnt == IW'(IMG_WORDS - 1));
  assign rb_ok   = (rb_sum + BRAM_IF1_DOUT) == wr_sum;
`else
  logic unused_dout;
  assign unused_dout = ^BRAM_IF1_DOUT;
  assign load_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (hs_in) begin
                if (IMG_WORDS == 1) state_n = FLUSH;
                else                state_n = LOAD;
              end
      LOAD:   if (hs_in && idx == IW'(IMG_WORDS - 1)) state_n = FLUSH;
`ifdef LOADER_READBACK_EN
      FLUSH:  state_n = VERIFY;
      VERIFY: if (rb_last) state_n = rb_ok ? START : REPORT;
`else
      FLUSH:  state_n = START;
`endif
      START:  state_n = RUN;
      RUN:    if (accept || wd == 32'(TIMEOUT_CYC - 1)) state_n = REPORT;
      REPORT: if (res_hs) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      wd            <= 32'd0;
      done_q        <= 1'b0;
      cnn_mode      <= 1'b0;
      cnn_start     <= 1'b0;
      io.s_ready    <= 1'b0;
      io.res_valid  <= 1'b0;
      io.res_data   <= 8'h00;
      timeout       <= 1'b0;
      BRAM_IF1_EN   <= 1'b0;
      BRAM_IF1_WE   <= 4'h0;
      BRAM_IF1_ADDR <= 32'h0;
      BRAM_IF1_DIN  <= 32'h0;
`ifdef LOADER_READBACK_EN
      load_err      <= 1'b0;
      wr_sum        <= 32'h0;
      rb_sum        <= 32'h0;
      rd_idx        <= '0;
      rd_cnt        <= '0;
      rd_vld        <= 1'b0;
`endif
    end else begin
      done_q     <= cnn_done;
      io.s_ready <= (state_n == IDLE) || (state_n == LOAD);
      cnn_start  <= (state_n == START);
      BRAM_IF1_EN <= 1'b0;
      BRAM_IF1_WE <= 4'h0;

      // Every accepted word becomes a write on the following cycle.
      if (hs_in) begin
        BRAM_IF1_EN   <= 1'b1;
        BRAM_IF1_WE   <= 4'hF;
        BRAM_IF1_ADDR <= BASE_ADDR + (32'(idx) << 2);
        BRAM_IF1_DIN  <= io.s_data;
        idx           <= idx + IW'(1);
        if (state == IDLE) begin
          cnn_mode <= io.mode_in;
          timeout  <= 1'b0;
        end
      end
      if (state_n == FLUSH) idx <= '0;

      wd <= (state == RUN) ? wd + 32'd1 : 32'd0;
      if (state == RUN && state_n == REPORT) begin
        io.res_valid <= 1'b1;
        if (accept) io.res_data <= cnn_result;
        else begin
          io.res_data <= 8'hFE;
          timeout     <= 1'b1;
        end
      end
      if (res_hs) io.res_valid <= 1'b0;

`ifdef LOADER_READBACK_EN
      // DOUT arrives one cycle after each read, so track which cycles issued reads.
      rd_vld <= BRAM_IF1_EN && (BRAM_IF1_WE == 4'h0);
      if (hs_in) wr_sum <= (state == IDLE) ? io.s_data : wr_sum + io.s_data;
      if (hs_in && state == IDLE) load_err <= 1'b0;
      if (state == FLUSH) begin
        BRAM_IF1_EN   <= 1'b1;
        BRAM_IF1_ADDR <= BASE_ADDR;
        rd_idx        <= IW'(1);
        rd_cnt        <= '0;
        rb_sum        <= 32'h0;
      end
      if (state == VERIFY) begin
        if (rd_idx < IW'(IMG_WORDS)) begin
          BRAM_IF1_EN   <= 1'b1;
          BRAM_IF1_ADDR <= BASE_ADDR + (32'(rd_idx) << 2);
          rd_idx        <= rd_idx + IW'(1);
        end
        if (rd_vld) begin
          rb_sum <= rb_sum + BRAM_IF1_DOUT;
          rd_cnt <= rd_cnt + IW'(1);
        end
        if (state_n == REPORT) begin
          load_err     <= 1'b1;
          io.res_valid <= 1'b1;
          io.res_data  <= 8'hFD;
        end
      end
`endif
    end
  end
endmodule

// File: tb/tb_cnn_frame_loader.sv
// Randomized bench for cnn_frame_loader with a BRAM model, accelerator stimulus and a write scoreboard.
module tb_cnn_frame_loader;
  localparam int          IMG  = 256;
  localparam logic [31:0] BASE = 32'h0;
  localparam int          TO   = 100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cnn_frame_loader_if io();
  logic        cnn_start, cnn_mode, cnn_done;
  logic [7:0]  cnn_result;
  logic [31:0] addr, din, dout;
  logic [3:0]  we;
  logic        en, busy, timeout, load_err;

  cnn_frame_loader #(.IMG_WORDS(IMG), .BASE_ADDR(BASE), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .io(io),
    .cnn_start(cnn_start), .cnn_mode(cnn_mode), .cnn_done(cnn_done), .cnn_result(cnn_result),
    .BRAM_IF1_ADDR(addr), .BRAM_IF1_WE(we), .BRAM_IF1_EN(en), .BRAM_IF1_DIN(din),
    .BRAM_IF1_DOUT(dout), .busy(busy), .timeout(timeout), .load_err(load_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model; optionally corrupts word 17 on reads.
  logic [31:0] mem [IMG];
  bit          corrupt = 1'b0;
  logic [7:0]  midx;
  assign midx = 8'((addr - BASE) >> 2);
  always @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) if (we[b]) mem[midx][8*b +: 8] <= din[8*b +: 8];
      dout <= mem[midx] ^ ((corrupt && midx == 8'd17) ? 32'h1 : 32'h0);
    end
  end

  // Bus log and reference write stream.
  logic [31:0] wr_a[$], wr_d[$], rd_a[$], exp_d[$];
  logic [3:0]  wr_we[$];
  int          n_start = 0;
  always @(negedge clk) begin
    if (en && we != 4'h0) begin
      wr_a.push_back(addr); wr_d.push_back(din); wr_we.push_back(we);
    end
    if (en && we == 4'h0) rd_a.push_back(addr);
    if (cnn_start) n_start++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_we.delete(); rd_a.delete(); exp_d.delete();
  endtask

  task automatic send_frame(input int n, input int gap, input bit mode, input bit idx_data,
                            output int last_hs);
    int i = 0;
    int guard = 0;
    last_hs = -1;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      io.s_valid = ($urandom_range(0, 99) >= gap);
      io.s_data  = idx_data ? 32'(i) : $urandom();
      io.mode_in = (i == 0) ? mode : ~mode;
      if (io.s_valid && io.s_ready) begin
        exp_d.push_back(io.s_data);
        i++;
        last_hs = cyc;
      end
    end
    @(negedge clk);
    io.s_valid = 1'b0;
    if (i < n) last_hs = -1;
  endtask

  task automatic wait_start(input int budget, output int at);
    at = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (cnn_start === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic wait_res(input int budget, output int at, output int srdy);
    at = -1; srdy = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (io.s_ready !== 1'b0) srdy++;
      if (io.res_valid === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic consume(input int hold, input logic [7:0] exp, output int unstable, output bit dropped);
    unstable = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (io.res_valid !== 1'b1 || io.res_data !== exp || io.s_ready !== 1'b0) unstable++;
    end
    io.res_ready = 1'b1;
    @(negedge clk);
    io.res_ready = 1'b0;
    dropped = (io.res_valid === 1'b0) && (busy === 1'b0);
  endtask

  task automatic diff_writes(output int bad);
    bad = 0;
    for (int k = 0; k < wr_a.size() && k < exp_d.size(); k++)
      if (wr_a[k] !== BASE + 32'(k) * 4 || wr_d[k] !== exp_d[k] || wr_we[k] !== 4'hF) bad++;
    if (wr_a.size() != exp_d.size()) bad++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({io.s_ready, en, we, cnn_start, cnn_mode, io.res_valid, busy, timeout, load_err} !== 13'h0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {io.s_ready, en, we, cnn_start, cnn_mode, io.res_valid, busy, timeout, load_err});
    end
    n_cmp++;
    if ({io.res_data, addr, din} !== 72'h0) begin
      n_bad++; $display("FAIL reset_data: got res=%h addr=%h din=%h want 0", io.res_data, addr, din);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (io.s_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_ready: got s_ready=%b busy=%b want 1/0", io.s_ready, busy);
    end
  endtask

  task automatic test_basic();
    int last, st, dc, ra, srdy, uns, bad, s0;
    bit dr;
    clear_logs(); s0 = n_start;
    send_frame(IMG, 0, 1'b1, 1'b1, last);
    n_cmp++;
    if (io.s_ready !== 1'b0) begin n_bad++; $display("FAIL ready_drop: got %b want 0", io.s_ready); end
    wait_start(600, st);
    n_cmp++;
`ifdef LOADER_READBACK_EN
    if (st < 0 || st <= last + 2) begin n_bad++; $display("FAIL start_latency: got %0d want > %0d", st, last + 2); end
`else
    if (st != last + 2) begin n_bad++; $display("FAIL start_latency: got %0d want %0d", st, last + 2); end
`endif
    n_cmp++;
    if (cnn_mode !== 1'b1) begin n_bad++; $display("FAIL mode_latch: got %b want 1", cnn_mode); end
    repeat (50) @(negedge clk);
    cnn_result = 8'd7; cnn_done = 1'b1; dc = cyc;
    wait_res(200, ra, srdy);
    n_cmp++;
    if (ra != dc + 1) begin n_bad++; $display("FAIL done_latency: got %0d want %0d", ra, dc + 1); end
    n_cmp++;
    if (io.res_data !== 8'd7 || busy !== 1'b1) begin
      n_bad++; $display("FAIL basic_result: got %h busy=%b want 07 busy=1", io.res_data, busy);
    end
    consume(0, 8'd7, uns, dr);
    cnn_done = 1'b0;
    n_cmp++;
    if (!dr) begin n_bad++; $display("FAIL res_drop: got valid=%b busy=%b want 0/0", io.res_valid, busy); end
    repeat (3) @(negedge clk);
    diff_writes(bad);
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL basic_writes: got %0d bad of %0d writes want 0 of %0d", bad, wr_a.size(), IMG); end
    n_cmp++;
    if (n_start - s0 != 1) begin n_bad++; $display("FAIL basic_starts: got %0d want 1", n_start - s0); end
    n_cmp++;
`ifdef LOADER_READBACK_EN
    if (rd_a.size() != IMG) begin n_bad++; $display("FAIL basic_reads: got %0d want %0d", rd_a.size(), IMG); end
`else
    if (rd_a.size() != 0) begin n_bad++; $display("FAIL basic_reads: got %0d want 0", rd_a.size()); end
`endif
  endtask

  task automatic test_gaps_backpressure();
    int last, st, dc, ra, srdy, uns, bad;
    bit dr;
    logic [7:0] r;
    clear_logs();
    send_frame(IMG, 40, 1'b0, 1'b0, last);
    wait_start(600, st);
    n_cmp++;
    if (st < 0 || cnn_mode !== 1'b0) begin n_bad++; $display("FAIL gap_start: got st=%0d mode=%b want start mode 0", st, cnn_mode); end
    r = 8'($urandom_range(0, 9));
    repeat (20) @(negedge clk);
    cnn_result = r; cnn_done = 1'b1; dc = cyc;
    wait_res(200, ra, srdy);
    cnn_result = ~r;
    n_cmp++;
    if (ra != dc + 1 || io.res_data !== r) begin
      n_bad++; $display("FAIL gap_result: got at=%0d data=%h want at=%0d data=%h", ra, io.res_data, dc + 1, r);
    end
    n_cmp++;
    if (srdy != 0) begin n_bad++; $display("FAIL gap_ready_run: got %0d cycles with s_ready want 0", srdy); end
    consume(10, r, uns, dr);
    cnn_done = 1'b0;
    n_cmp++;
    if (uns != 0 || !dr) begin n_bad++; $display("FAIL gap_hold: got %0d unstable drop=%b want 0/1", uns, dr); end
    diff_writes(bad);
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL gap_writes: got %0d bad of %0d writes want 0 of %0d", bad, wr_a.size(), exp_d.size()); end
  endtask

  task automatic test_timeout();
    int last, st, ra, srdy, uns, s0;
    bit dr;
    clear_logs(); s0 = n_start;
    send_frame(IMG, 20, 1'b1, 1'b0, last);
    wait_start(600, st);
    wait_res(TO + 50, ra, srdy);
    n_cmp++;
    if (st < 0 || ra != st + 1 + TO) begin n_bad++; $display("FAIL timeout_cycle: got %0d want %0d", ra, st + 1 + TO); end
    n_cmp++;
    if (io.res_data !== 8'hFE || timeout !== 1'b1) begin
      n_bad++; $display("FAIL timeout_code: got %h to=%b want fe to=1", io.res_data, timeout);
    end
    consume(3, 8'hFE, uns, dr);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (timeout !== 1'b1 || n_start - s0 != 1 || uns != 0) begin
      n_bad++; $display("FAIL timeout_sticky: got to=%b starts=%0d uns=%0d want 1/1/0", timeout, n_start - s0, uns);
    end
  endtask

  task automatic test_done_stuck();
    int last, st, dc, ra, srdy, uns, early;
    bit dr;
    logic [7:0] r;
    clear_logs();
    cnn_done = 1'b1; cnn_result = 8'hAA;
    send_frame(IMG, 10, 1'b0, 1'b0, last);
    n_cmp++;
    if (timeout !== 1'b0) begin n_bad++; $display("FAIL timeout_clear: got %b want 0", timeout); end
    wait_start(600, st);
    early = 0;
    repeat (20) begin @(negedge clk); if (io.res_valid !== 1'b0) early++; end
    cnn_done = 1'b0;
    repeat (3) begin @(negedge clk); if (io.res_valid !== 1'b0) early++; end
    n_cmp++;
    if (st < 0 || early != 0) begin n_bad++; $display("FAIL stale_done: got %0d early results st=%0d want 0", early, st); end
    r = 8'($urandom_range(0, 200));
    cnn_result = r; cnn_done = 1'b1; dc = cyc;
    wait_res(100, ra, srdy);
    n_cmp++;
    if (ra != dc + 1 || io.res_data !== r) begin
      n_bad++; $display("FAIL rise_capture: got at=%0d data=%h want at=%0d data=%h", ra, io.res_data, dc + 1, r);
    end
    consume(2, r, uns, dr);
    cnn_done = 1'b0;
  endtask

  task automatic test_midframe_reset();
    int last, st, dc, ra, srdy, uns, bad;
    bit dr;
    clear_logs();
    send_frame(101, 0, 1'b1, 1'b1, last);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({en, we, io.s_ready, cnn_start, busy} !== 8'h0) begin
      n_bad++; $display("FAIL midreset: got en=%b we=%h rdy=%b st=%b busy=%b want 0", en, we, io.s_ready, cnn_start, busy);
    end
    rst = 1'b0;
    clear_logs();
    @(negedge clk);
    send_frame(IMG, 10, 1'b1, 1'b0, last);
    wait_start(600, st);
    repeat (30) @(negedge clk);
    cnn_result = 8'd42; cnn_done = 1'b1; dc = cyc;
    wait_res(100, ra, srdy);
    n_cmp++;
    if (st < 0 || io.res_data !== 8'd42) begin n_bad++; $display("FAIL restart_result: got %h st=%0d want 2a", io.res_data, st); end
    consume(1, 8'd42, uns, dr);
    cnn_done = 1'b0;
    n_cmp++;
    if (wr_a.size() == 0 || wr_a[0] !== BASE || exp_d.size() == 0 || wr_d[0] !== exp_d[0]) begin
      n_bad++; $display("FAIL restart_word0: got %0d writes first addr=%h want addr %h", wr_a.size(), (wr_a.size() > 0) ? wr_a[0] : 32'hx, BASE);
    end
    diff_writes(bad);
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL restart_writes: got %0d bad of %0d want 0 of %0d", bad, wr_a.size(), exp_d.size()); end
  endtask

  task automatic test_readback();
    int last, st, ra, srdy, uns, s0, bad;
    bit dr;
    clear_logs(); s0 = n_start; corrupt = 1'b1;
    send_frame(IMG, 0, 1'b1, 1'b0, last);
`ifdef LOADER_READBACK_EN
    wait_res(800, ra, srdy);
    n_cmp++;
    if (ra < 0 || load_err !== 1'b1 || io.res_data !== 8'hFD) begin
      n_bad++; $display("FAIL readback_err: got at=%0d err=%b data=%h want err=1 data=fd", ra, load_err, io.res_data);
    end
    consume(2, 8'hFD, uns, dr);
    bad = (rd_a.size() != IMG) ? 1 : 0;
    for (int k = 0; k < rd_a.size(); k++) if (rd_a[k] !== BASE + 32'(k) * 4) bad++;
    n_cmp++;
    if (bad != 0 || n_start != s0) begin
      n_bad++; $display("FAIL readback_seq: got %0d bad reads %0d starts want 0/0", bad, n_start - s0);
    end
`else
    wait_start(600, st);
    n_cmp++;
    if (st != last + 2 || load_err !== 1'b0) begin
      n_bad++; $display("FAIL noreadback_start: got st=%0d err=%b want st=%0d err=0", st, load_err, last + 2);
    end
    repeat (10) @(negedge clk);
    cnn_result = 8'd3; cnn_done = 1'b1;
    wait_res(100, ra, srdy);
    n_cmp++;
    if (io.res_data !== 8'd3 || load_err !== 1'b0 || rd_a.size() != 0) begin
      n_bad++; $display("FAIL noreadback_result: got %h err=%b reads=%0d want 03/0/0", io.res_data, load_err, rd_a.size());
    end
    consume(1, 8'd3, uns, dr);
    cnn_done = 1'b0;
`endif
    corrupt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    io.s_valid = 1'b0; io.s_data = 32'h0; io.mode_in = 1'b0; io.res_ready = 1'b0;
    cnn_done = 1'b0; cnn_result = 8'h0;
    test_reset();
    test_basic();
    test_gaps_backpressure();
    test_timeout();
    test_done_stuck();
    test_midframe_reset();
    test_readback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
